// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one word fetch, returns the instruction from a loader-filled array.
// Latency: accept at cycle T, rsp_valid first high at T+LATENCY (1..15).
// Backpressure: one outstanding fetch; the response is held until rsp_ready, req_ready is low meanwhile.
module imem_responder #(
    parameter logic [31:0] ADDR_BASE  = 32'h80000000,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 1,
    parameter logic [31:0] ERR_INST   = 32'h00100073
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_inst,
    output logic                  rsp_err,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_idx,
    input  logic [31:0]           ld_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic [31:0]             mem [DEPTH];

    logic [31:0]             off;
    logic                    addr_err;
    logic [DEPTH_LOG2-1:0]   rd_idx;
    logic [31:0]             rd_word;
    logic                    unused_off_bits;

    // Below-base addresses wrap to a huge offset and land in the range check.
    assign off             = req_addr - ADDR_BASE;
    assign addr_err        = (req_addr[1:0] != 2'b00) || (off[31:DEPTH_LOG2+2] != '0);
    assign rd_idx          = off[DEPTH_LOG2+1:2];
    assign rd_word         = mem[rd_idx];
    assign unused_off_bits = ^off[1:0];

    assign req_ready = (state == IDLE) && !reset;

    // Loader port is independent of reset and FSM state.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_idx] <= ld_data;
        end
    end

    // Word is captured at accept, so a same-cycle or later loader write never reaches the response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_inst  <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rsp_inst <= addr_err ? ERR_INST : rd_word;
                        rsp_err  <= addr_err;
                        if (LATENCY > 1) begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances (LATENCY 1 and 3) against a cycle-count reference model.
module tb_imem_responder;

    localparam logic [31:0] BASE = 32'h80000000;
    localparam logic [31:0] EI   = 32'h00100073;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_inst  [2];
    logic        rsp_err   [2];
    logic        ld_en;
    logic [9:0]  ld_idx;
    logic [31:0] ld_data;

    imem_responder #(.LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_inst(rsp_inst[0]), .rsp_err(rsp_err[0]),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
    );

    imem_responder #(.LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_inst(rsp_inst[1]), .rsp_err(rsp_err[1]),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: a pending fetch is ready once cyc reaches accept cycle + latency.
    bit          m_pend [2];
    int          m_rdy  [2];
    logic [31:0] m_inst [2];
    logic        m_err  [2];
    logic [31:0] m_mem  [1024];
    int          cyc    = 0;
    bit          chk_on = 0;

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [32:0] lookup(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (a[1:0] != 2'b00 || off >= 32'd4096) return {1'b1, EI};
        return {1'b0, m_mem[off[11:2]]};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_pend[k] <= 1'b0;
            end else if (m_pend[k] && cyc >= m_rdy[k] && rsp_ready[k] === 1'b1) begin
                m_pend[k] <= 1'b0;
            end else if (!m_pend[k] && req_valid[k] === 1'b1) begin
                m_pend[k] <= 1'b1;
                m_rdy[k]  <= cyc + lat(k);
                {m_err[k], m_inst[k]} <= lookup(req_addr[k]);
            end
        end
        if (ld_en === 1'b1) m_mem[ld_idx] <= ld_data;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                logic exp_vld;
                exp_vld = m_pend[k] && cyc >= m_rdy[k];
                chk($sformatf("req_ready[%0d]", k), {31'd0, req_ready[k]}, {31'd0, !reset && !m_pend[k]});
                chk($sformatf("rsp_valid[%0d]", k), {31'd0, rsp_valid[k]}, {31'd0, exp_vld});
                if (exp_vld) begin
                    chk($sformatf("rsp_inst[%0d]", k), rsp_inst[k], m_inst[k]);
                    chk($sformatf("rsp_err[%0d]", k), {31'd0, rsp_err[k]}, {31'd0, m_err[k]});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int k, input logic [31:0] a, output logic [31:0] inst, output logic err);
        bit ok;
        ok   = 0;
        inst = '0;
        err  = 1'b0;
        rsp_ready[k] = 1'b1;
        req_addr[k]  = a;
        req_valid[k] = 1'b1;
        for (int i = 0; i < 20 && req_ready[k] !== 1'b1; i++) step();
        step();
        req_valid[k] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid[k] === 1'b1) begin
                inst = rsp_inst[k];
                err  = rsp_err[k];
                ok   = 1;
                break;
            end
            step();
        end
        step();
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL fetch_timeout: inst %0d addr %h got no rsp_valid want rsp_valid within 20 cycles", k, a);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish want finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] inst;
        logic        err;
        int          n;
        int          acc;
        int          r;

        reset   = 1'b1;
        ld_en   = 1'b0;
        ld_idx  = '0;
        ld_data = '0;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_addr[k]  = BASE;
            rsp_ready[k] = 1'b0;
        end
        step();
        chk_on = 1;

        // Fill the array while reset is high.
        for (int i = 0; i < 1024; i++) begin
            ld_en   = 1'b1;
            ld_idx  = 10'(i);
            ld_data = (i == 0) ? 32'h00500093 : (i == 1) ? 32'h00108113 : $urandom;
            step();
        end
        ld_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("reset_rsp_valid", {31'd0, rsp_valid[k]}, 32'd0);
            chk("reset_rsp_inst", rsp_inst[k], 32'd0);
            chk("reset_rsp_err", {31'd0, rsp_err[k]}, 32'd0);
            chk("reset_req_ready", {31'd0, req_ready[k]}, 32'd0);
        end
        reset = 1'b0;
        step();

        // LATENCY 1 single fetch.
        chk("t1_ready_T", {31'd0, req_ready[0]}, 32'd1);
        req_valid[0] = 1'b1;
        req_addr[0]  = BASE;
        rsp_ready[0] = 1'b1;
        step();
        req_valid[0] = 1'b0;
        chk("t1_valid_T1", {31'd0, rsp_valid[0]}, 32'd1);
        chk("t1_inst", rsp_inst[0], 32'h00500093);
        chk("t1_err", {31'd0, rsp_err[0]}, 32'd0);
        step();
        chk("t1_ready_T2", {31'd0, req_ready[0]}, 32'd1);
        chk("t1_valid_T2", {31'd0, rsp_valid[0]}, 32'd0);

        // LATENCY 3 with the response held for four cycles.
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h80000004;
        rsp_ready[1] = 1'b0;
        step();
        req_valid[1] = 1'b0;
        chk("t2_valid_T1", {31'd0, rsp_valid[1]}, 32'd0);
        step();
        chk("t2_valid_T2", {31'd0, rsp_valid[1]}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_valid_held", {31'd0, rsp_valid[1]}, 32'd1);
            chk("t2_inst_held", rsp_inst[1], 32'h00108113);
            chk("t2_ready_low", {31'd0, req_ready[1]}, 32'd0);
        end
        step();
        rsp_ready[1] = 1'b1;
        chk("t2_valid_T7", {31'd0, rsp_valid[1]}, 32'd1);
        step();
        rsp_ready[1] = 1'b0;
        chk("t2_ready_T8", {31'd0, req_ready[1]}, 32'd1);
        chk("t2_valid_T8", {31'd0, rsp_valid[1]}, 32'd0);

        // Address decode errors and the last valid word.
        fetch(0, 32'h80000002, inst, err);
        chk("t3_misaligned_err", {31'd0, err}, 32'd1);
        chk("t3_misaligned_inst", inst, EI);
        fetch(0, 32'h80001000, inst, err);
        chk("t3_over_err", {31'd0, err}, 32'd1);
        fetch(1, 32'h7FFFFFFC, inst, err);
        chk("t3_below_err", {31'd0, err}, 32'd1);
        chk("t3_below_inst", inst, EI);
        fetch(0, 32'h80000FFC, inst, err);
        chk("t3_last_err", {31'd0, err}, 32'd0);

        // Loader write to the word being accepted in the same cycle.
        rsp_ready[0] = 1'b1;
        req_valid[0] = 1'b1;
        req_addr[0]  = BASE;
        ld_en   = 1'b1;
        ld_idx  = 10'd0;
        ld_data = 32'hDEADBEEF;
        step();
        req_valid[0] = 1'b0;
        ld_en        = 1'b0;
        chk("t4_old_word", rsp_inst[0], 32'h00500093);
        step();
        fetch(0, BASE, inst, err);
        chk("t4_new_word", inst, 32'hDEADBEEF);

        // Reset one cycle after an accept drops the fetch.
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h80000008;
        rsp_ready[1] = 1'b1;
        step();
        req_valid[1] = 1'b0;
        reset = 1'b1;
        #1;
        chk("t5_ready_in_reset", {31'd0, req_ready[1]}, 32'd0);
        step();
        chk("t5_ready_in_reset2", {31'd0, req_ready[1]}, 32'd0);
        reset = 1'b0;
        #1;
        chk("t5_ready_after_reset", {31'd0, req_ready[1]}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t5_no_valid", {31'd0, rsp_valid[1]}, 32'd0);
        end

        // Back-to-back stream on LATENCY 1.
        n = 0;
        acc = 0;
        r = 0;
        req_valid[0] = 1'b1;
        rsp_ready[0] = 1'b1;
        req_addr[0]  = BASE;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid[0] === 1'b1) begin
                if (r == 0) chk("t6_first", rsp_inst[0], 32'hDEADBEEF);
                if (r == 1) chk("t6_second", rsp_inst[0], 32'h00108113);
                r++;
            end
            if (req_ready[0] === 1'b1) begin
                step();
                n++;
                acc++;
                req_addr[0] = BASE + 32'(n) * 32'd4;
            end else begin
                step();
            end
        end
        chk("t6_accepts", 32'(acc), 32'd10);
        req_valid[0] = 1'b0;
        step();
        step();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                int mode;
                mode = $urandom_range(0, 9);
                req_valid[k] = ($urandom_range(0, 2) != 0);
                rsp_ready[k] = $urandom_range(0, 1) == 1;
                if (mode == 0)      req_addr[k] = $urandom;
                else if (mode == 1) req_addr[k] = BASE + 32'($urandom_range(0, 4095));
                else                req_addr[k] = BASE + 32'($urandom_range(0, 1023)) * 32'd4;
            end
            ld_en   = ($urandom_range(0, 4) == 0);
            ld_idx  = 10'($urandom);
            ld_data = $urandom;
            reset   = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        ld_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            rsp_ready[k] = 1'b1;
        end
        for (int i = 0; i < 6; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
